// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request/grant and register-file write bundle
//
// Purpose : groups the three writeback sources (0 ALU, 1 LSU, 2 MUL) and the
//           register-file write port of regfile_wb_arbiter into one bundle.
// Signals : sN_valid/sN_addr/sN_data  source N request (driven by the source)
//           sN_ready                  combinational grant back to source N
//           wr_en/wr_addr/wr_data     registered register-file write port
//           pending                   one-hot mask of the register written now
// Modports: master - the writeback sources and register-file observer
//           slave  - the arbiter
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic                   s0_valid;
   logic [ADDR_W-1:0]      s0_addr;
   logic [DATA_W-1:0]      s0_data;
   logic                   s0_ready;
   logic                   s1_valid;
   logic [ADDR_W-1:0]      s1_addr;
   logic [DATA_W-1:0]      s1_data;
   logic                   s1_ready;
   logic                   s2_valid;
   logic [ADDR_W-1:0]      s2_addr;
   logic [DATA_W-1:0]      s2_data;
   logic                   s2_ready;
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [DATA_W-1:0]      wr_data;
   logic [2**ADDR_W-1:0]   pending;

   modport master (
      output s0_valid, s0_addr, s0_data,
      output s1_valid, s1_addr, s1_data,
      output s2_valid, s2_addr, s2_data,
      input  s0_ready, s1_ready, s2_ready,
      input  wr_en, wr_addr, wr_data, pending
   );

   modport slave (
      input  s0_valid, s0_addr, s0_data,
      input  s1_valid, s1_addr, s1_data,
      input  s2_valid, s2_addr, s2_data,
      output s0_ready, s1_ready, s2_ready,
      output wr_en, wr_addr, wr_data, pending
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - three-source writeback arbiter feeding one register-file write port
//
// Purpose : grants at most one of three writeback sources per cycle and
//           forwards the granted write to the register file one cycle later
//           through a registered output stage. Writes to register 0 are
//           granted but dropped.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - regfile_wb_arbiter_if.slave (requests, grants, write port)
// Config  : WB_FIXED_PRIO_EN defined   -> fixed priority, source 0 highest
//           WB_FIXED_PRIO_EN undefined -> round-robin after the last grant
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_arbiter_if.slave  bus
);

   logic [2:0]            w_valid;
   logic                  w_any;
   logic [1:0]            w_gidx;
   logic [2:0]            w_grant;
   logic                  w_xfer;
   logic                  w_do_write;
   logic [ADDR_W-1:0]     w_sel_addr;
   logic [DATA_W-1:0]     w_sel_data;
   logic [2**ADDR_W-1:0]  w_pending;

   logic                  r_wr_en;
   logic [ADDR_W-1:0]     r_wr_addr;
   logic [DATA_W-1:0]     r_wr_data;

   assign w_valid = {bus.s2_valid, bus.s1_valid, bus.s0_valid};

`ifndef WB_FIXED_PRIO_EN
   // Index of the last source that completed a transfer. Reset to 2 so the
   // rotating search starts at source 0 right after reset.
   logic [1:0] r_last;
`endif

   always_comb begin
      w_any  = 1'b0;
      w_gidx = 2'd0;
`ifdef WB_FIXED_PRIO_EN
      if (w_valid[0]) begin
         w_any = 1'b1; w_gidx = 2'd0;
      end else if (w_valid[1]) begin
         w_any = 1'b1; w_gidx = 2'd1;
      end else if (w_valid[2]) begin
         w_any = 1'b1; w_gidx = 2'd2;
      end
`else
      // Search order begins with the source after the last granted one.
      case (r_last)
         2'd0: begin
            if (w_valid[1]) begin
               w_any = 1'b1; w_gidx = 2'd1;
            end else if (w_valid[2]) begin
               w_any = 1'b1; w_gidx = 2'd2;
            end else if (w_valid[0]) begin
               w_any = 1'b1; w_gidx = 2'd0;
            end
         end
         2'd1: begin
            if (w_valid[2]) begin
               w_any = 1'b1; w_gidx = 2'd2;
            end else if (w_valid[0]) begin
               w_any = 1'b1; w_gidx = 2'd0;
            end else if (w_valid[1]) begin
               w_any = 1'b1; w_gidx = 2'd1;
            end
         end
         default: begin
            if (w_valid[0]) begin
               w_any = 1'b1; w_gidx = 2'd0;
            end else if (w_valid[1]) begin
               w_any = 1'b1; w_gidx = 2'd1;
            end else if (w_valid[2]) begin
               w_any = 1'b1; w_gidx = 2'd2;
            end
         end
      endcase
`endif
   end

   // Grants are suppressed while reset is held so no source sees a transfer.
   assign w_xfer  = w_any & ~rst;
   assign w_grant = w_xfer ? (3'b001 << w_gidx) : 3'b000;

   assign bus.s0_ready = w_grant[0];
   assign bus.s1_ready = w_grant[1];
   assign bus.s2_ready = w_grant[2];

   always_comb begin
      w_sel_addr = bus.s0_addr;
      w_sel_data = bus.s0_data;
      case (w_gidx)
         2'd1: begin
            w_sel_addr = bus.s1_addr;
            w_sel_data = bus.s1_data;
         end
         2'd2: begin
            w_sel_addr = bus.s2_addr;
            w_sel_data = bus.s2_data;
         end
         default: begin
            w_sel_addr = bus.s0_addr;
            w_sel_data = bus.s0_data;
         end
      endcase
   end

   // x0 is hard-wired zero: the transfer completes but nothing is written.
   assign w_do_write = w_xfer && (w_sel_addr != '0);

   // Address/data only move on a real write so they hold across idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_do_write;
         if (w_do_write) begin
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
         end
      end
   end

`ifndef WB_FIXED_PRIO_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= 2'd2;
      end else if (w_xfer) begin
         r_last <= w_gidx;
      end
   end
`endif

   always_comb begin
      w_pending = '0;
      if (r_wr_en) begin
         w_pending[r_wr_addr] = 1'b1;
      end
   end

   assign bus.wr_en   = r_wr_en;
   assign bus.wr_addr = r_wr_addr;
   assign bus.wr_data = r_wr_data;
   assign bus.pending = w_pending;

endmodule
